store_buffer: RTL and testbench
===============================

STORE_BUFFER -- requirements
Module: store_buffer

Interface
REQ-001 Parameter DEPTH, default 4: number of buffered store entries; power of two, 2..16.
REQ-002 Parameter AW, default 32: store address width.
REQ-003 Parameter DW, default 32: store data width.
REQ-004 clk  input  1  the single clock; all state updates on its rising edge.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 mem_write  input  1  store strobe from the pipelined core's MemWrite.
REQ-007 data_adr  input  AW  store address from the core's DataAdr.
REQ-008 write_data  input  DW  store data from the core's WriteData.
REQ-009 full  output  1  high when count==DEPTH; drives the core's stall request.
REQ-010 empty  output  1  high when count==0.
REQ-011 count  output  $clog2(DEPTH+1)  number of occupied entries.
REQ-012 bus_valid  output  1  head entry is presented on the downstream bus.
REQ-013 bus_addr  output  AW  head entry address.
REQ-014 bus_data  output  DW  head entry data.
REQ-015 bus_ready  input  1  downstream memory accepts the head entry this cycle.
REQ-016 overflow  output  1  sticky flag: a store was dropped.

Function
REQ-017 Circular FIFO; head/tail pointers wrap modulo DEPTH.
REQ-018 Push occurs when mem_write==1 and full==0; the entry {data_adr, write_data} is written at tail.
REQ-019 mem_write==1 with full==1 drops the store, even if a pop occurs that cycle; overflow sets next cycle.
REQ-020 bus_valid equals !empty; bus_addr/bus_data show the head entry combinationally (first-word fall-through).
REQ-021 Pop occurs when bus_valid==1 and bus_ready==1; head advances at that edge.
REQ-022 bus_addr/bus_data stay stable while bus_valid==1 and bus_ready==0.
REQ-023 Latency: a store pushed into an empty buffer at edge N appears with bus_valid==1 in the cycle after N; there is no input-to-bus bypass.
REQ-024 Simultaneous push and pop with 0<count<DEPTH: count unchanged; both pointers advance.
REQ-025 bus_ready while empty is ignored: no pointer or count change.
REQ-026 Store order on the bus equals acceptance order.
REQ-027 full, empty, count are derived from registered state only, with no combinational path from any input.

Reset
REQ-028 On reset at a clock edge: pointers=0, count=0, empty=1, full=0, bus_valid=0, overflow=0.
REQ-029 bus_addr/bus_data are 0 after reset.
REQ-030 Reset takes priority over simultaneous push/pop, and buffered entries are discarded, including mid-drain.

Configuration
REQ-031 Macro STORE_BUF_COALESCE_EN enables write coalescing.
REQ-032 With STORE_BUF_COALESCE_EN defined: a push whose data_adr equals the youngest entry's address overwrites that entry's data with no count change, unless that entry is the head being popped in the same cycle, in which case a normal push occurs.
REQ-033 A coalesce is permitted when full==1 and does not set overflow.
REQ-034 Without STORE_BUF_COALESCE_EN: every accepted store occupies a new entry; no address comparison logic exists.

Verification
REQ-035 Reset, then mem_write=1, adr=0x100, data=0xAAAA5555, bus_ready=0 -> the next cycle shows bus_valid=1, bus_addr=0x100, bus_data=0xAAAA5555, count=1; it is held 3 cycles unchanged.
REQ-036 Push 4 stores (adr 0x10,0x14,0x18,0x1C) with bus_ready=0 -> full=1, count=4; a 5th push of 0x20 is dropped, overflow=1; draining with bus_ready=1 yields 0x10,0x14,0x18,0x1C in order, then empty=1.
REQ-037 count=2, push 0x40 and bus_ready=1 in the same cycle -> count stays 2; the head advances; 0x40 drains last.
REQ-038 count=3 with bus_ready=1, assert reset for one cycle -> count=0, bus_valid=0, overflow=0; no further bus transfers.
REQ-039 Coalescing enabled: push adr 0x80 data 1, then adr 0x80 data 2 with bus_ready=0 -> count=1, bus_data=2. Coalescing disabled: count=2, drain order 1 then 2.
REQ-040 Full buffer, pop and push in the same cycle (no coalesce) -> push dropped, overflow=1, count=3 next cycle.

Source files
------------

// File: rtl/store_buffer.sv
// store_buffer: circular store buffer between a pipelined core and a
// slower memory bus. Stores are queued in acceptance order and drained
// from the head with first-word fall-through on the bus_* interface.
// Optional feature: define STORE_BUF_COALESCE_EN to merge a store into
// the youngest entry when it targets the same address.
module store_buffer #(
    parameter int DEPTH = 4,
    parameter int AW    = 32,
    parameter int DW    = 32
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       mem_write,
    input  logic [AW-1:0]              data_adr,
    input  logic [DW-1:0]              write_data,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic                       bus_valid,
    output logic [AW-1:0]              bus_addr,
    output logic [DW-1:0]              bus_data,
    input  logic                       bus_ready,
    output logic                       overflow
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);

    logic [PW-1:0]             head_q, head_d;
    logic [PW-1:0]             tail_q, tail_d;
    logic [CW-1:0]             count_q, count_d;
    logic                      overflow_q, overflow_d;
    logic [DEPTH-1:0][AW-1:0]  addr_mem_q, addr_mem_d;
    logic [DEPTH-1:0][DW-1:0]  data_mem_q, data_mem_d;

    logic push;
    logic pop;
    logic drop;

    // Status flags come straight from registered state so the stall path
    // into the core never sees a combinational loop through our inputs.
    assign full      = (count_q == CW'(DEPTH));
    assign empty     = (count_q == '0);
    assign count     = count_q;
    assign bus_valid = !empty;
    assign overflow  = overflow_q;

    // Head entry is shown directly from storage; zero while nothing is queued.
    assign bus_addr = bus_valid ? addr_mem_q[head_q] : '0;
    assign bus_data = bus_valid ? data_mem_q[head_q] : '0;

    assign pop = bus_valid && bus_ready;

`ifdef STORE_BUF_COALESCE_EN
    logic [PW-1:0] youngest;
    logic          coalesce;

    assign youngest = tail_q - PW'(1);

    // Merge into the youngest entry on an address match, unless that entry
    // is the single head entry leaving this very cycle.
    assign coalesce = mem_write && !empty
                      && (addr_mem_q[youngest] == data_adr)
                      && !(pop && (count_q == CW'(1)));
    assign push     = mem_write && !full && !coalesce;
    assign drop     = mem_write && full && !coalesce;
`else
    assign push = mem_write && !full;
    assign drop = mem_write && full;
`endif

    // Next-state computation for pointers, occupancy, storage and sticky overflow.
    always_comb begin
        head_d     = head_q;
        tail_d     = tail_q;
        count_d    = count_q;
        overflow_d = overflow_q;
        addr_mem_d = addr_mem_q;
        data_mem_d = data_mem_q;

        if (push) begin
            addr_mem_d[tail_q] = data_adr;
            data_mem_d[tail_q] = write_data;
            tail_d             = tail_q + PW'(1);
        end

`ifdef STORE_BUF_COALESCE_EN
        if (coalesce) begin
            data_mem_d[youngest] = write_data;
        end
`endif

        if (pop) begin
            head_d = head_q + PW'(1);
        end

        case ({push, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase

        if (drop) begin
            overflow_d = 1'b1;
        end
    end

    // State registers; reset discards every queued entry and clears overflow.
    always_ff @(posedge clk) begin
        if (reset) begin
            head_q     <= '0;
            tail_q     <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
            addr_mem_q <= '0;
            data_mem_q <= '0;
        end else begin
            head_q     <= head_d;
            tail_q     <= tail_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
            addr_mem_q <= addr_mem_d;
            data_mem_q <= data_mem_d;
        end
    end

endmodule

// File: tb/tb_store_buffer.sv
// Testbench for store_buffer (DEPTH=4, AW=DW=32) with directed vectors.
// Define STORE_BUF_COALESCE_EN to check the coalescing build.
module tb_store_buffer;

    logic        clk;
    logic        reset;
    logic        mem_write;
    logic [31:0] data_adr;
    logic [31:0] write_data;
    logic        full;
    logic        empty;
    logic [2:0]  count;
    logic        bus_valid;
    logic [31:0] bus_addr;
    logic [31:0] bus_data;
    logic        bus_ready;
    logic        overflow;

    int checks;
    int errors;

    store_buffer #(.DEPTH(4), .AW(32), .DW(32)) dut (
        .clk        (clk),
        .reset      (reset),
        .mem_write  (mem_write),
        .data_adr   (data_adr),
        .write_data (write_data),
        .full       (full),
        .empty      (empty),
        .count      (count),
        .bus_valid  (bus_valid),
        .bus_addr   (bus_addr),
        .bus_data   (bus_data),
        .bus_ready  (bus_ready),
        .overflow   (overflow)
    );

    // Free-running 10 ns clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Advance one rising edge and settle 1 ns past it before sampling.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset     = 1'b1;
        mem_write = 1'b0;
        bus_ready = 1'b0;
        tick();
        reset = 1'b0;
    endtask

    task automatic push_one(input logic [31:0] a, input logic [31:0] d);
        mem_write  = 1'b1;
        data_adr   = a;
        write_data = d;
        tick();
        mem_write = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if (count !== 3'd0) begin errors++; $display("[TB] FAIL reset_count got %0d want 0", count); end
        checks++;
        if (empty !== 1'b1 || full !== 1'b0) begin errors++; $display("[TB] FAIL reset_flags got empty=%b full=%b want 1/0", empty, full); end
        checks++;
        if (bus_valid !== 1'b0 || overflow !== 1'b0) begin errors++; $display("[TB] FAIL reset_valid_ovf got %b/%b want 0/0", bus_valid, overflow); end
        checks++;
        if (bus_addr !== 32'h0 || bus_data !== 32'h0) begin errors++; $display("[TB] FAIL reset_bus got %h/%h want 0/0", bus_addr, bus_data); end
    endtask

    task automatic test_single_push();
        do_reset();
        push_one(32'h100, 32'hAAAA5555);
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (bus_valid !== 1'b1 || bus_addr !== 32'h100 || bus_data !== 32'hAAAA5555 || count !== 3'd1) begin
                errors++;
                $display("[TB] FAIL single_hold[%0d] got v=%b a=%h d=%h c=%0d want 1/100/aaaa5555/1",
                         i, bus_valid, bus_addr, bus_data, count);
            end
            tick();
        end
        bus_ready = 1'b1;
        tick();
        bus_ready = 1'b0;
        checks++;
        if (empty !== 1'b1 || bus_valid !== 1'b0) begin errors++; $display("[TB] FAIL single_drain got empty=%b v=%b want 1/0", empty, bus_valid); end
    endtask

    task automatic test_ready_when_empty();
        do_reset();
        bus_ready = 1'b1;
        tick();
        tick();
        bus_ready = 1'b0;
        checks++;
        if (count !== 3'd0 || empty !== 1'b1) begin errors++; $display("[TB] FAIL empty_ready got count=%0d empty=%b want 0/1", count, empty); end
        push_one(32'h60, 32'h6);
        checks++;
        if (count !== 3'd1 || bus_addr !== 32'h60 || bus_data !== 32'h6) begin
            errors++; $display("[TB] FAIL empty_ready_push got c=%0d a=%h d=%h want 1/60/6", count, bus_addr, bus_data);
        end
    endtask

    task automatic test_full_overflow();
        logic [31:0] exp_adr [4];
        exp_adr = '{32'h10, 32'h14, 32'h18, 32'h1C};
        do_reset();
        for (int i = 0; i < 4; i++) push_one(exp_adr[i], exp_adr[i] + 32'h1000);
        checks++;
        if (full !== 1'b1 || count !== 3'd4 || overflow !== 1'b0) begin
            errors++; $display("[TB] FAIL fill got full=%b c=%0d ovf=%b want 1/4/0", full, count, overflow);
        end
        push_one(32'h20, 32'h1020);
        checks++;
        if (overflow !== 1'b1 || count !== 3'd4) begin errors++; $display("[TB] FAIL drop got ovf=%b c=%0d want 1/4", overflow, count); end
        bus_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (bus_valid !== 1'b1 || bus_addr !== exp_adr[i] || bus_data !== exp_adr[i] + 32'h1000) begin
                errors++; $display("[TB] FAIL drain[%0d] got v=%b a=%h d=%h want 1/%h/%h",
                                   i, bus_valid, bus_addr, bus_data, exp_adr[i], exp_adr[i] + 32'h1000);
            end
            tick();
        end
        bus_ready = 1'b0;
        checks++;
        if (empty !== 1'b1 || overflow !== 1'b1) begin errors++; $display("[TB] FAIL drain_end got empty=%b ovf=%b want 1/1", empty, overflow); end
    endtask

    task automatic test_push_pop();
        do_reset();
        push_one(32'h30, 32'h3);
        push_one(32'h34, 32'h4);
        mem_write  = 1'b1;
        data_adr   = 32'h40;
        write_data = 32'h5;
        bus_ready  = 1'b1;
        tick();
        mem_write = 1'b0;
        checks++;
        if (count !== 3'd2 || bus_addr !== 32'h34) begin errors++; $display("[TB] FAIL push_pop got c=%0d a=%h want 2/34", count, bus_addr); end
        tick();
        checks++;
        if (count !== 3'd1 || bus_addr !== 32'h40 || bus_data !== 32'h5) begin
            errors++; $display("[TB] FAIL push_pop_last got c=%0d a=%h d=%h want 1/40/5", count, bus_addr, bus_data);
        end
        tick();
        bus_ready = 1'b0;
        checks++;
        if (empty !== 1'b1) begin errors++; $display("[TB] FAIL push_pop_empty got %b want 1", empty); end
    endtask

    task automatic test_reset_mid_drain();
        do_reset();
        for (int i = 0; i < 4; i++) push_one(32'h50 + 32'(4 * i), 32'(i));
        push_one(32'h70, 32'h7);
        bus_ready = 1'b1;
        tick();
        checks++;
        if (count !== 3'd3 || overflow !== 1'b1 || bus_addr !== 32'h54) begin
            errors++; $display("[TB] FAIL pre_reset got c=%0d ovf=%b a=%h want 3/1/54", count, overflow, bus_addr);
        end
        reset = 1'b1;
        tick();
        reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (count !== 3'd0 || bus_valid !== 1'b0 || overflow !== 1'b0) begin
                errors++; $display("[TB] FAIL mid_reset[%0d] got c=%0d v=%b ovf=%b want 0/0/0", i, count, bus_valid, overflow);
            end
            tick();
        end
        bus_ready = 1'b0;
    endtask

    task automatic test_full_push_pop();
        do_reset();
        for (int i = 0; i < 4; i++) push_one(32'h90 + 32'(4 * i), 32'h900 + 32'(i));
        mem_write  = 1'b1;
        data_adr   = 32'hA0;
        write_data = 32'hA00;
        bus_ready  = 1'b1;
        tick();
        mem_write = 1'b0;
        checks++;
        if (overflow !== 1'b1 || count !== 3'd3 || bus_addr !== 32'h94) begin
            errors++; $display("[TB] FAIL full_pp got ovf=%b c=%0d a=%h want 1/3/94", overflow, count, bus_addr);
        end
        tick();
        tick();
        checks++;
        if (bus_addr !== 32'h9C || bus_data !== 32'h903) begin errors++; $display("[TB] FAIL full_pp_tail got a=%h d=%h want 9c/903", bus_addr, bus_data); end
        tick();
        bus_ready = 1'b0;
        checks++;
        if (empty !== 1'b1) begin errors++; $display("[TB] FAIL full_pp_empty got %b want 1", empty); end
    endtask

    task automatic test_coalesce();
        do_reset();
        push_one(32'h80, 32'h1);
        push_one(32'h80, 32'h2);
`ifdef STORE_BUF_COALESCE_EN
        checks++;
        if (count !== 3'd1 || bus_data !== 32'h2) begin errors++; $display("[TB] FAIL coalesce got c=%0d d=%h want 1/2", count, bus_data); end
        push_one(32'h84, 32'h3);
        push_one(32'h88, 32'h4);
        push_one(32'h8C, 32'h5);
        push_one(32'h8C, 32'h6);
        checks++;
        if (count !== 3'd4 || overflow !== 1'b0) begin errors++; $display("[TB] FAIL coalesce_full got c=%0d ovf=%b want 4/0", count, overflow); end
        bus_ready = 1'b1;
        tick();
        tick();
        tick();
        checks++;
        if (bus_addr !== 32'h8C || bus_data !== 32'h6) begin errors++; $display("[TB] FAIL coalesce_full_data got a=%h d=%h want 8c/6", bus_addr, bus_data); end
        tick();
        bus_ready = 1'b0;
`else
        checks++;
        if (count !== 3'd2 || bus_data !== 32'h1) begin errors++; $display("[TB] FAIL no_coalesce got c=%0d d=%h want 2/1", count, bus_data); end
        bus_ready = 1'b1;
        tick();
        checks++;
        if (bus_addr !== 32'h80 || bus_data !== 32'h2 || count !== 3'd1) begin
            errors++; $display("[TB] FAIL no_coalesce_second got a=%h d=%h c=%0d want 80/2/1", bus_addr, bus_data, count);
        end
        tick();
        bus_ready = 1'b0;
`endif
        checks++;
        if (empty !== 1'b1) begin errors++; $display("[TB] FAIL coalesce_empty got %b want 1", empty); end
    endtask

    // Run every scenario in order, then report.
    initial begin
        checks     = 0;
        errors     = 0;
        reset      = 1'b1;
        mem_write  = 1'b0;
        data_adr   = '0;
        write_data = '0;
        bus_ready  = 1'b0;
        test_reset();
        test_single_push();
        test_ready_when_empty();
        test_full_overflow();
        test_push_pop();
        test_reset_mid_drain();
        test_full_push_pop();
        test_coalesce();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
